// File: rtl/avr_bus_mem.sv
// Code store, data RAM and MMIO block (console TX FIFO, latched cycle counter)
// for the avr_cpu bus. Every output is registered except the FIFO drain port.
module avr_bus_mem #(
  parameter int          CODE_AW = 7,
  parameter int          DATA_AW = 8,
  parameter logic [15:0] IO_BASE = 16'hFF00,
  parameter int          FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        pc,
  output logic [15:0]        cdata,
  input  logic               prog_wen,
  input  logic [CODE_AW-1:0] prog_addr,
  input  logic [15:0]        prog_data,
  input  logic [15:0]        data_addr,
  input  logic               data_wen,
  input  logic               data_ren,
  input  logic [7:0]         data_write,
  output logic [7:0]         data_read,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready
);

  localparam int          CODE_DEPTH = 2 ** CODE_AW;
  localparam int          RAM_DEPTH  = 2 ** DATA_AW;
  localparam int          FIFO_DEPTH = 2 ** FIFO_AW;
  localparam logic [16:0] RAM_LIMIT  = 17'(RAM_DEPTH);
  localparam logic [FIFO_AW:0] FIFO_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [3:0] {
    OFF_TXDATA = 4'd0,
    OFF_STATUS = 4'd1,
    OFF_CYCLE0 = 4'd2,
    OFF_CYCLE1 = 4'd3,
    OFF_CYCLE2 = 4'd4,
    OFF_CYCLE3 = 4'd5
  } io_off_e;

  logic [15:0] code_mem [CODE_DEPTH];
  logic [7:0]  ram_mem  [RAM_DEPTH];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic [15:0]        cdata_q, cdata_d;
  logic [7:0]         data_read_q, data_read_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [31:0]        cycle_q, cycle_d;
  logic [23:0]        shadow_q, shadow_d;

  logic       is_io, is_ram, empty, full, pop, push, ram_wen;
  logic [3:0] io_off;
  logic       unused_pc_hi;

  // Upper pc bits are deliberately ignored: the code store aliases.
  assign unused_pc_hi = ^pc[15:CODE_AW];

  // IO window takes priority over RAM when the two overlap.
  assign is_io   = (data_addr[15:4] == IO_BASE[15:4]);
  assign is_ram  = !is_io && ({1'b0, data_addr} < RAM_LIMIT);
  assign io_off  = data_addr[3:0];
  assign ram_wen = data_wen && is_ram;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FIFO_FULL);
  assign tx_valid = !empty;
  assign tx_data  = fifo_mem[rd_ptr_q];
  assign pop      = tx_valid && tx_ready;

  // NOTE: storage arrays have no reset so they map onto plain RAM; only the
  // control state below is reset, and all clocked state uses <= so every
  // read in this cycle sees the pre-edge value (read-old-data on collisions).
  always_ff @(posedge clk) begin
    if (prog_wen) code_mem[prog_addr] <= prog_data;
    if (ram_wen)  ram_mem[data_addr[DATA_AW-1:0]] <= data_write;
    if (push)     fifo_mem[wr_ptr_q] <= data_write;
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    cdata_d     = code_mem[pc[CODE_AW-1:0]];
    data_read_d = 8'h00;
    shadow_d    = shadow_q;
    overflow_d  = overflow_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    cycle_d     = cycle_q + 32'd1;
    push        = 1'b0;

    if (is_io) begin
      case (io_off)
        OFF_STATUS: data_read_d = {5'b0, overflow_q, full, empty};
        OFF_CYCLE0: data_read_d = cycle_q[7:0];
        OFF_CYCLE1: data_read_d = shadow_q[7:0];
        OFF_CYCLE2: data_read_d = shadow_q[15:8];
        OFF_CYCLE3: data_read_d = shadow_q[23:16];
        default:    data_read_d = 8'h00;
      endcase
    end else if (is_ram) begin
      data_read_d = ram_mem[data_addr[DATA_AW-1:0]];
    end

    // Reading CYCLE0 freezes the upper bytes so a multi-byte read is coherent.
    if (is_io && data_ren && io_off == OFF_CYCLE0) shadow_d = cycle_q[31:8];

    if (is_io && data_wen && io_off == OFF_STATUS && data_write[2]) overflow_d = 1'b0;

    if (is_io && data_wen && io_off == OFF_TXDATA) begin
      if (!full || pop) push = 1'b1;
      else              overflow_d = 1'b1;  // placed after the clear: set wins
    end

    if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdata_q     <= '0;
      data_read_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      cycle_q     <= '0;
      shadow_q    <= '0;
    end else begin
      cdata_q     <= cdata_d;
      data_read_q <= data_read_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      cycle_q     <= cycle_d;
      shadow_q    <= shadow_d;
    end
  end

  assign cdata     = cdata_q;
  assign data_read = data_read_q;

endmodule

// File: doc/avr_bus_mem.md
Name: avr_bus_mem

Overview:
Parametrised code-ROM / data-RAM / MMIO subsystem for the avr_cpu bus (pc/cdata, data_addr/wen/ren/read/write). It replaces the fixed 128-word code and 256-byte data arrays with configurable depths. It adds a loadable code store, a memory-mapped console TX FIFO with a valid/ready drain port, and a latched 32-bit cycle counter. Sits directly beside avr_cpu in system and bench tops.

Parameters:
CODE_AW, 7, code store address bits; depth 2**CODE_AW 16-bit words
DATA_AW, 8, data RAM address bits; depth 2**DATA_AW bytes
IO_BASE, 16'hFF00, base of 16-byte MMIO window; low 4 bits must be 0
FIFO_AW, 3, TX FIFO address bits; depth 2**FIFO_AW

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
pc  in  16  code word address from CPU
cdata  out  16  registered code word
prog_wen  in  1  code store write strobe (loader)
prog_addr  in  CODE_AW  code store write address
prog_data  in  16  code store write data
data_addr  in  16  data byte address
data_wen  in  1  data write strobe
data_ren  in  1  data read strobe (qualifies read side effects only)
data_write  in  8  write data
data_read  out  8  registered read data
tx_valid  out  1  FIFO non-empty
tx_data  out  8  FIFO head byte (show-ahead)
tx_ready  in  1  sink accepts tx_data this cycle

Behaviour:
- Reset (reset low, async): cdata=0, data_read=0, tx_valid=0, FIFO pointers/count=0, overflow=0, cycle counter=0, shadow=0. Code and RAM arrays are not cleared.
- Code: cdata <= code[pc[CODE_AW-1:0]] every clock; 1-cycle latency. pc upper bits ignored (wrap/alias). prog_wen writes code[prog_addr]. If prog_addr equals pc in the same cycle, cdata returns old word.
- Decode on data_addr: IO if data_addr[15:4]==IO_BASE[15:4]; else RAM if data_addr < 2**DATA_AW; else UNMAPPED. IO wins on overlap.
- Read: data_read registered every clock from decoded target; valid the cycle after data_addr. UNMAPPED reads 0x00. A RAM read and write to the same address in the same cycle returns old data.
- Write (data_wen): RAM stores data_write. UNMAPPED writes are ignored. IO writes are per register map.
- MMIO (offset = data_addr[3:0]):
  - 0 TXDATA: write pushes byte; reads 0x00.
  - 1 STATUS: read {5'b0, overflow, full, empty}. Writing bit2=1 clears overflow.
  - 2..5 CYCLE0..3: read counter bytes, LSB first. A read of CYCLE0 with data_ren high returns the live low byte and loads a 24-bit shadow with counter[31:8]. CYCLE1..3 return the shadow. Writes ignored.
  - 6..15 read 0x00, writes ignored.
- Cycle counter: 32-bit, increments every clock out of reset, wraps 0xFFFFFFFF->0.
- FIFO:
  - Pop when tx_valid && tx_ready.
  - Push when TXDATA written and (not full, or pop same cycle).
  - Push to a full FIFO with no pop drops the byte and sets sticky overflow. Overflow set and clear in the same cycle: set wins.
  - Simultaneous push+pop keeps count unchanged.
  - Empty pop impossible (tx_valid=0).
  - Pointers wrap modulo depth.
  - tx_data is undefined when tx_valid=0 and must not be checked then.
- Reset asserted mid-operation discards FIFO contents and returns tx_valid to 0 immediately (async).

Test Plan:
- Load code[0..3]=0000,E011,E019,E022 via prog_wen; drive pc=0..3 -> cdata equals each word one cycle later. pc=0x0081 with CODE_AW=7 -> code[1]=E011.
- Write RAM 0x10<=0xA5 and 0x11<=0x5A, then read -> 0xA5, 0x5A next cycle. Same-cycle read+write 0x10<=0x33 -> read 0xA5, then 0x33. Read 0x0200 -> 0x00.
- Hold tx_ready=0, write TXDATA 9 times at 0xFF00 (depth 8) -> STATUS=0x06 (full, overflow). Raise tx_ready -> bytes 1..8 drain in order; STATUS=0x05. Write 0x04 to STATUS -> 0x01.
- With FIFO full and tx_ready=1, write TXDATA 0x99 -> count stays 8; 0x99 emerges last; overflow stays 0.
- After 300 clocks out of reset, read CYCLE0 then CYCLE1 -> values consistent with counter at CYCLE0 read (0x2C/0x01 ±pipeline offset). A second CYCLE1 read without CYCLE0 is unchanged.
- Assert reset low mid-drain with 3 bytes queued -> tx_valid, data_read, cdata are 0 asynchronously. After release, STATUS=0x01 and CYCLE restarts from 0.
